cpu_bus_unit: RTL

Parametrised external bus interface for the CPU core. It turns single-beat core requests (address, write data, read/write, opcode-fetch marker) into registered bus cycles. Each cycle is stretched by the READY pin, and an optional timeout aborts a bus that never becomes ready. It generalises the core's fixed 16-bit/8-bit addressing and NMOS-only READY handling to configurable widths and a selectable write-stall mode.

---
 rtl/cpu_bus_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/cpu_bus_unit.sv
// External bus interface: turns single-beat core requests into registered
// bus cycles stretched by READY, with an optional READY timeout.
module cpu_bus_unit #(
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int WRITE_STALL = 0,
   parameter int TIMEOUT     = 0
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          CLK_en,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic          req_rnw,
   input  logic          req_sync,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic [AW-1:0] Address_bus,
   output logic [DW-1:0] Data_out,
   output logic          Data_oe,
   input  logic [DW-1:0] Data_in,
   output logic          RnW,
   output logic          SYNC,
   input  logic          READY,
   output logic [15:0]   stall_count
);

   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           busy, ready_done, timeout_hit, bus_done, accept;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ready_done = 1'b0;
      case (state)
         READ:    ready_done = READY;
         WRITE:   ready_done = READY | (WRITE_STALL == 0);
         default: ready_done = 1'b0;
      endcase
   end

   assign busy = (state != IDLE);

   // The timeout only matters when READY has not already finished the cycle.
   always_comb begin
      timeout_hit = 1'b0;
      if (TIMEOUT > 0 && busy && !ready_done && wait_cnt == WCW'(TIMEOUT - 1))
         timeout_hit = 1'b1;
   end

   assign bus_done  = ready_done | timeout_hit;
   assign req_ready = CLK_en & ((state == IDLE) | bus_done);
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_nxt = state;
      if (CLK_en) begin
         if (accept)
            state_nxt = req_rnw ? READ : WRITE;
         else if (bus_done)
            state_nxt = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         Address_bus <= '0;
         Data_out    <= '0;
         Data_oe     <= 1'b0;
         RnW         <= 1'b1;
         SYNC        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         stall_count <= '0;
         wait_cnt    <= '0;
      end else if (CLK_en) begin
         rsp_valid <= bus_done;
         if (bus_done) begin
            rsp_err  <= timeout_hit;
            // Data_out still holds the completing write's data even if a new accept reloads it.
            rsp_data <= timeout_hit ? '1 : ((state == READ) ? Data_in : Data_out);
         end
         if (accept) begin
            Address_bus <= req_addr;
            Data_out    <= req_wdata;
            Data_oe     <= ~req_rnw;
            RnW         <= req_rnw;
            SYNC        <= req_sync;
            wait_cnt    <= '0;
         end else if (bus_done) begin
            Data_oe  <= 1'b0;
            RnW      <= 1'b1;
            SYNC     <= 1'b0;
            wait_cnt <= '0;
         end else if (busy) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (stall_count != 16'hFFFF)
               stall_count <= stall_count + 16'd1;
         end
      end
   end

endmodule
